predictor_ctrl: RTL

Controller for a table of 2-bit saturating branch counters: accepts prediction lookups, returns the counter MSB as the prediction, and tracks in-flight predictions in order until their outcomes resolve. It applies counter updates, detects mispredictions, flushes younger in-flight predictions, and sequences table initialisation. It sits between fetch, which issues lookups, and the branch-resolve stage, which returns outcomes.

---
 rtl/predictor_pkg.sv | 27 ++
 rtl/predictor_queue.sv | 76 +++++++
 rtl/predictor_ctrl.sv | 139 +++++++++++++
 3 files changed

// File: rtl/predictor_pkg.sv
// predictor_pkg: shared types and helpers for the branch predictor controller.
//   cnt_t      - 2-bit saturating counter
//   CNT_*      - counter initial value and saturation bounds
//   state_t    - controller FSM states
//   cnt_next() - saturating counter update toward the resolved direction
package predictor_pkg;

    typedef logic [1:0] cnt_t;

    localparam cnt_t CNT_INIT = 2'b11;
    localparam cnt_t CNT_MAX  = 2'b11;
    localparam cnt_t CNT_MIN  = 2'b00;

    typedef enum logic [1:0] {
        INIT,
        RUN,
        FLUSH
    } state_t;

    function automatic cnt_t cnt_next(input cnt_t cnt, input logic taken);
        if (taken)
            return (cnt == CNT_MAX) ? CNT_MAX : cnt + 2'd1;
        else
            return (cnt == CNT_MIN) ? CNT_MIN : cnt - 2'd1;
    endfunction

endpackage

// File: rtl/predictor_queue.sv
// predictor_queue: in-order FIFO of in-flight predictions {idx, pred}.
//   push/push_idx/push_pred - enqueue at write slot (wr_tag)
//   pop                     - dequeue oldest entry (head_idx/head_pred)
//   flush                   - drop all entries, pointers return to slot 0
//   full/empty/count        - occupancy status
// The caller never pushes when full or pops when empty.
module predictor_queue
    import predictor_pkg::*;
#(
    parameter int INDEX_W = 4,
    parameter int DEPTH   = 4
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       push,
    input  logic [INDEX_W-1:0]         push_idx,
    input  logic                       push_pred,
    input  logic                       pop,
    input  logic                       flush,
    output logic [INDEX_W-1:0]         head_idx,
    output logic                       head_pred,
    output logic                       full,
    output logic                       empty,
    output logic [$clog2(DEPTH):0]     count,
    output logic [$clog2(DEPTH)-1:0]   wr_tag
);

    localparam int TAG_W = $clog2(DEPTH);
    localparam int CNT_W = TAG_W + 1;

    logic [INDEX_W-1:0] idx_mem  [DEPTH];
    logic               pred_mem [DEPTH];
    logic [TAG_W-1:0]   wr_ptr;
    logic [TAG_W-1:0]   rd_ptr;
    logic [CNT_W-1:0]   cnt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            cnt    <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            cnt    <= '0;
        end else begin
            if (push)
                wr_ptr <= wr_ptr + TAG_W'(1);
            if (pop)
                rd_ptr <= rd_ptr + TAG_W'(1);
            unique case ({push, pop})
                2'b10:   cnt <= cnt + CNT_W'(1);
                2'b01:   cnt <= cnt - CNT_W'(1);
                default: ;
            endcase
        end
    end

    // Entry storage carries no reset; occupancy decides what is live.
    always_ff @(posedge clk) begin
        if (push && !flush) begin
            idx_mem[wr_ptr]  <= push_idx;
            pred_mem[wr_ptr] <= push_pred;
        end
    end

    always_comb begin
        head_idx  = idx_mem[rd_ptr];
        head_pred = pred_mem[rd_ptr];
        full      = (cnt == CNT_W'(DEPTH));
        empty     = (cnt == '0);
        count     = cnt;
        wr_tag    = wr_ptr;
    end

endmodule

// File: rtl/predictor_ctrl.sv
// predictor_ctrl: 2-bit saturating branch counter table with in-order
// tracking of in-flight predictions.
//   clk, rst (async, active-high), clr (sync re-initialise)
//   req_valid/req_idx/req_ready          - lookup handshake from fetch
//   pred_valid/pred_taken/pred_tag       - registered prediction, 1-cycle pulse
//   res_valid/res_taken/res_ready        - outcome of oldest in-flight branch
//   mispredict                           - 1-cycle pulse on wrong prediction
//   occ                                  - in-flight count
//   miss_count                           - mispredictions since reset/clr
module predictor_ctrl
    import predictor_pkg::*;
#(
    parameter int INDEX_W = 4,
    parameter int DEPTH   = 4
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       clr,
    input  logic                       req_valid,
    input  logic [INDEX_W-1:0]         req_idx,
    output logic                       req_ready,
    output logic                       pred_valid,
    output logic                       pred_taken,
    output logic [$clog2(DEPTH)-1:0]   pred_tag,
    input  logic                       res_valid,
    input  logic                       res_taken,
    output logic                       res_ready,
    output logic                       mispredict,
    output logic [$clog2(DEPTH):0]     occ,
    output logic [15:0]                miss_count
);

    localparam int TAG_W   = $clog2(DEPTH);
    localparam int ENTRIES = 2 ** INDEX_W;

    cnt_t               tbl [ENTRIES];
    state_t             state;
    logic [INDEX_W-1:0] ptr;

    logic               q_push, q_pop, q_flush;
    logic [INDEX_W-1:0] q_head_idx;
    logic               q_head_pred;
    logic               q_full, q_empty;
    logic [TAG_W:0]     q_count;
    logic [TAG_W-1:0]   q_wr_tag;

    logic               acc_req, acc_res, is_miss;
    cnt_t               upd_cnt, look_cnt;

    predictor_queue #(
        .INDEX_W (INDEX_W),
        .DEPTH   (DEPTH)
    ) u_queue (
        .clk       (clk),
        .rst       (rst),
        .push      (q_push),
        .push_idx  (req_idx),
        .push_pred (look_cnt[1]),
        .pop       (q_pop),
        .flush     (q_flush),
        .head_idx  (q_head_idx),
        .head_pred (q_head_pred),
        .full      (q_full),
        .empty     (q_empty),
        .count     (q_count),
        .wr_tag    (q_wr_tag)
    );

    always_comb begin
        req_ready = (state == RUN) && !q_full;
        res_ready = (state == RUN) && !q_empty;
        acc_req   = req_valid && req_ready;
        acc_res   = res_valid && res_ready;
        upd_cnt   = cnt_next(tbl[q_head_idx], res_taken);
        is_miss   = acc_res && (q_head_pred != res_taken);
        // A lookup hitting the entry resolved on the same edge sees the
        // updated counter rather than the stale table value.
        look_cnt  = (acc_res && (q_head_idx == req_idx)) ? upd_cnt : tbl[req_idx];
        // A lookup arriving with a mispredicting resolution is younger than
        // the wrong branch, so it is dropped along with the flushed entries.
        q_push    = acc_req && !is_miss && !clr;
        q_pop     = acc_res && !clr;
        q_flush   = clr || is_miss;
        occ       = q_count;
    end

    // Table storage has no reset; INIT overwrites every entry.
    always_ff @(posedge clk) begin
        if (!clr) begin
            if (state == INIT)
                tbl[ptr] <= CNT_INIT;
            else if (acc_res)
                tbl[q_head_idx] <= upd_cnt;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= INIT;
            ptr        <= '0;
            pred_valid <= 1'b0;
            pred_taken <= 1'b0;
            pred_tag   <= '0;
            mispredict <= 1'b0;
            miss_count <= '0;
        end else if (clr) begin
            state      <= INIT;
            ptr        <= '0;
            pred_valid <= 1'b0;
            pred_taken <= 1'b0;
            pred_tag   <= '0;
            mispredict <= 1'b0;
            miss_count <= '0;
        end else begin
            pred_valid <= q_push;
            mispredict <= is_miss;
            if (q_push) begin
                pred_taken <= look_cnt[1];
                pred_tag   <= q_wr_tag;
            end
            if (is_miss)
                miss_count <= miss_count + 16'd1;
            unique case (state)
                INIT: begin
                    ptr <= ptr + INDEX_W'(1);
                    if (ptr == INDEX_W'(ENTRIES - 1))
                        state <= RUN;
                end
                RUN: begin
                    if (is_miss)
                        state <= FLUSH;
                end
                FLUSH: state <= RUN;
                default: state <= INIT;
            endcase
        end
    end

endmodule
